wsc_ctrl: RTL and testbench
===========================

Name: wsc_ctrl

Overview:
- Crossing sequencer for the wsc puzzle block.
- On start, it drives the wolf/sheep/cab move commands to run the 7-crossing solution in either direction.
- Every cycle, it checks the puzzle state against the expected trajectory and flags any deviation.
- It sits between a top-level requester (start/abort, status) and the wsc block (move inputs, state output).

Parameters:
- WAIT_MAX, 3: max cycles ARM waits for a valid start position before timeout (min 2).
- CNT_W, 8: width of the successful-run counter.

Ports:
- clk  in  1  system clock, all flops rising-edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  request a solve run; level-sampled in IDLE/DONE/ERROR.
- abort  in  1  force return to IDLE from any state.
- state  in  4  wsc state: [3] farmer, [2] wolf, [1] sheep, [0] cabbage (0 = bank A, 1 = bank B).
- wolf  out  1  move wolf with farmer this crossing.
- sheep  out  1  move sheep with farmer this crossing.
- cab  out  1  move cabbage with farmer this crossing.
- busy  out  1  high in ARM, RUN, CHKEND.
- done  out  1  high in DONE.
- error  out  1  high in ERROR.
- err_code  out  3  000 none, 001 bad start, 010 timeout, 011 mismatch, 100 eaten.
- step  out  3  current crossing index 0..6; 7 in CHKEND/DONE.
- dir  out  1  latched direction: 0 = A->B (start 0000), 1 = B->A (start 1111).
- runs_ok  out  CNT_W  saturating count of completed runs.

Behaviour:
- wsc contract: every rising edge, state[3] toggles; any flagged passenger on the farmer's bank toggles with it. So state is updated 1 cycle after the command.
- Commands: wolf/sheep/cab are combinational. At most one is high; all are 0 outside ARM/RUN and on any mismatch.
- Reset: FSM=IDLE, step=0, dir=0, err_code=000, runs_ok=0. All outputs 0.
- Trajectory for dir=0 (pre-state -> command), steps 0..6:
  - 0: 0000 -> S
  - 1: 1010 -> none
  - 2: 0010 -> W
  - 3: 1110 -> S
  - 4: 0100 -> C
  - 5: 1101 -> none
  - 6: 0101 -> S
  - End state: 1111.
- dir=1: every expected state is XORed with 1111; the command sequence is identical.
- IDLE / DONE / ERROR: start=1 -> ARM next edge. This clears err_code, clears wait count and sets step=0.
- ARM, each cycle:
  - state[2:0] not 000/111 -> ERROR, code 001.
  - state==0000 or 1111 -> latch dir=state[0], drive step-0 command this cycle, go RUN with step=1.
  - Else (farmer on the far bank) -> wait; wait count reaching WAIT_MAX -> ERROR, code 010.
- RUN step k:
  - state==expected[k] -> drive cmd[k], step<=k+1; at k=6 go CHKEND.
  - Mismatch -> outputs 0, ERROR, code 011.
- CHKEND: state==end state -> DONE, runs_ok++ (saturates at all-ones). Else ERROR, code 011.
- DONE / ERROR hold (sticky) until start or abort. step/dir hold their last values.
- abort: highest priority. Outputs 0 the same cycle, IDLE next edge, err_code cleared, runs_ok kept.
- start held high in DONE immediately re-arms (back-to-back runs allowed).
- Asserting rst mid-run: immediate async return to reset values.

Optional Feature:
- Macro: WSC_CTRL_SAFETY_EN.
- Defined: a combinational hazard is unsafe = (s[2]==s[1] && s[3]!=s[1]) || (s[1]==s[0] && s[3]!=s[0]).
  - While busy, hazard -> commands 0 and ERROR with code 100. This takes priority over mismatch.
  - Hazard in IDLE is ignored.
- Undefined: no hazard logic; code 100 is never produced. Mismatch checking alone catches deviations.

Test Plan:
1. Reset, state=0000, start pulse -> commands S,-,W,S,C,-,S on 7 consecutive cycles. DONE with state=1111, runs_ok=1, step=7, err_code=000.
2. start with state=1111 (model free-running) -> dir=1, same command order. Final state 0000, done=1.
3. start with state=0100 -> ERROR in 1 cycle, err_code=001, no command asserted.
4. Mid-run, force state=0110 at step 2 -> commands 0 that cycle, err_code=011. Next start with state=0000 clears the error and completes.
5. abort asserted at step 4 -> commands 0 same cycle, IDLE next edge, busy=0, runs_ok unchanged.
6. Model frozen at 1000 with WAIT_MAX=3 -> err_code=010 after 3 ARM cycles. Also, with WSC_CTRL_SAFETY_EN, inject 1001 in RUN -> err_code=100.

Source files
------------

// File: rtl/wsc_ctrl.sv
// Crossing sequencer for the wsc puzzle: drives the 7-crossing solution and checks the trajectory.
// Optional hazard check enabled by defining WSC_CTRL_SAFETY_EN.
module wsc_ctrl #(
    parameter int unsigned WAIT_MAX = 3,
    parameter int unsigned CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [3:0]       state,
    output logic             wolf,
    output logic             sheep,
    output logic             cab,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [2:0]       err_code,
    output logic [2:0]       step,
    output logic             dir,
    output logic [CNT_W-1:0] runs_ok
);

    localparam int unsigned WAIT_W = $clog2(WAIT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_RUN,
        S_CHKEND,
        S_DONE,
        S_ERROR
    } fsm_e;

    fsm_e              fsm_q, fsm_d;
    logic [2:0]        step_q, step_d;
    logic [2:0]        code_q, code_d;
    logic              dir_q, dir_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [CNT_W-1:0]  runs_q, runs_d;
    logic [2:0]        cmd;
    logic [3:0]        exp_st;
    logic [2:0]        exp_cmd;
    logic              hazard;
    logic              in_busy;

    // Expected pre-state (for dir=0) and command {wolf,sheep,cab} per crossing
    always_comb begin
        exp_st  = 4'b1111;
        exp_cmd = 3'b000;
        case (step_q)
            3'd0: begin exp_st = 4'b0000; exp_cmd = 3'b010; end
            3'd1: begin exp_st = 4'b1010; exp_cmd = 3'b000; end
            3'd2: begin exp_st = 4'b0010; exp_cmd = 3'b100; end
            3'd3: begin exp_st = 4'b1110; exp_cmd = 3'b010; end
            3'd4: begin exp_st = 4'b0100; exp_cmd = 3'b001; end
            3'd5: begin exp_st = 4'b1101; exp_cmd = 3'b000; end
            3'd6: begin exp_st = 4'b0101; exp_cmd = 3'b010; end
            default: begin exp_st = 4'b1111; exp_cmd = 3'b000; end
        endcase
    end

`ifdef WSC_CTRL_SAFETY_EN
    assign hazard = ((state[2] == state[1]) && (state[3] != state[1])) ||
                    ((state[1] == state[0]) && (state[3] != state[0]));
`else
    assign hazard = 1'b0;
`endif

    assign in_busy = fsm_q inside {S_ARM, S_RUN, S_CHKEND};

    always_comb begin
        fsm_d  = fsm_q;
        step_d = step_q;
        code_d = code_q;
        dir_d  = dir_q;
        wait_d = wait_q;
        runs_d = runs_q;
        cmd    = 3'b000;
        if (abort) begin
            fsm_d  = S_IDLE;
            code_d = 3'b000;
        end else if (hazard && in_busy) begin
            fsm_d  = S_ERROR;
            code_d = 3'b100;
        end else begin
            case (fsm_q)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        fsm_d  = S_ARM;
                        code_d = 3'b000;
                        wait_d = '0;
                        step_d = 3'd0;
                    end
                end
                S_ARM: begin
                    if ((state[2:0] != 3'b000) && (state[2:0] != 3'b111)) begin
                        fsm_d  = S_ERROR;
                        code_d = 3'b001;
                    end else if (state[3] == state[0]) begin
                        dir_d  = state[0];
                        cmd    = 3'b010;
                        step_d = 3'd1;
                        fsm_d  = S_RUN;
                    end else if (wait_q == WAIT_W'(WAIT_MAX - 1)) begin
                        fsm_d  = S_ERROR;
                        code_d = 3'b010;
                    end else begin
                        wait_d = wait_q + WAIT_W'(1);
                    end
                end
                S_RUN: begin
                    if (state == (exp_st ^ {4{dir_q}})) begin
                        cmd    = exp_cmd;
                        step_d = step_q + 3'd1;
                        if (step_q == 3'd6) fsm_d = S_CHKEND;
                    end else begin
                        fsm_d  = S_ERROR;
                        code_d = 3'b011;
                    end
                end
                S_CHKEND: begin
                    if (state == {4{~dir_q}}) begin
                        fsm_d = S_DONE;
                        if (runs_q != '1) runs_d = runs_q + CNT_W'(1);
                    end else begin
                        fsm_d  = S_ERROR;
                        code_d = 3'b011;
                    end
                end
                default: fsm_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fsm_q  <= S_IDLE;
            step_q <= 3'd0;
            code_q <= 3'b000;
            dir_q  <= 1'b0;
            wait_q <= '0;
            runs_q <= '0;
        end else begin
            fsm_q  <= fsm_d;
            step_q <= step_d;
            code_q <= code_d;
            dir_q  <= dir_d;
            wait_q <= wait_d;
            runs_q <= runs_d;
        end
    end

    assign {wolf, sheep, cab} = cmd;
    assign busy     = in_busy;
    assign done     = (fsm_q == S_DONE);
    assign error    = (fsm_q == S_ERROR);
    assign err_code = code_q;
    assign step     = step_q;
    assign dir      = dir_q;
    assign runs_ok  = runs_q;

endmodule

// File: tb/tb_wsc_ctrl.sv
// Self-checking bench for wsc_ctrl: directed vector table, hand sequences, and a randomized
// run against a puzzle-level reference model.
module tb_wsc_ctrl;

    localparam int unsigned CW  = 4;
    localparam int unsigned WMX = 3;
`ifdef WSC_CTRL_SAFETY_EN
    localparam bit SAFE = 1'b1;
`else
    localparam bit SAFE = 1'b0;
`endif

    localparam logic [3:0] TRAJ [7] = '{4'b0000, 4'b1010, 4'b0010, 4'b1110, 4'b0100, 4'b1101, 4'b0101};
    localparam logic [2:0] CMDS [7] = '{3'b010, 3'b000, 3'b100, 3'b010, 3'b001, 3'b000, 3'b010};

    logic          clk = 1'b0, rst = 1'b0, start = 1'b0, abort = 1'b0;
    logic [3:0]    state = 4'b0000;
    logic          wolf, sheep, cab, busy, done, error, dir;
    logic [2:0]    err_code, step;
    logic [CW-1:0] runs_ok;

    int checks = 0;
    int errors = 0;

    wsc_ctrl #(.WAIT_MAX(WMX), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .state(state),
        .wolf(wolf), .sheep(sheep), .cab(cab), .busy(busy), .done(done), .error(error),
        .err_code(err_code), .step(step), .dir(dir), .runs_ok(runs_ok)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          start, abort;
        logic [3:0]    st;
        logic [2:0]    cmd;
        logic          busy, done, err;
        logic [2:0]    code, step;
        logic          dir;
        logic [CW-1:0] runs;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [31:0] obs();
        return 32'({wolf, sheep, cab, busy, done, error, err_code, step, dir, runs_ok});
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push(input int s, input int a, input int st, input int cmd, input int b,
                        input int d, input int e, input int code, input int stp,
                        input int dr, input int r);
        vec_t v;
        v.start = 1'(s);  v.abort = 1'(a);  v.st = 4'(st);  v.cmd = 3'(cmd);
        v.busy = 1'(b);   v.done = 1'(d);   v.err = 1'(e);  v.code = 3'(code);
        v.step = 3'(stp); v.dir = 1'(dr);   v.runs = CW'(r);
        tbl.push_back(v);
    endtask

    // Full solve: ARM cycle, 6 crossings, end check, then one DONE cycle
    task automatic push_run(input int d, input int pd, input int r);
        int m;
        int rn;
        m  = (d != 0) ? 15 : 0;
        rn = (r + 1 > 15) ? 15 : r + 1;
        push(0, 0, m, 3'b010, 1, 0, 0, 0, 0, pd, r);
        for (int k = 1; k < 7; k++)
            push(0, 0, int'(TRAJ[k]) ^ m, int'(CMDS[k]), 1, 0, 0, 0, k, d, r);
        push(0, 0, 15 ^ m, 0, 1, 0, 0, 0, 7, d, r);
        push(0, 0, 15 ^ m, 0, 0, 1, 0, 0, 7, d, rn);
    endtask

    function automatic bit hz(input logic [3:0] s);
        return ((s[2] == s[1]) && (s[3] != s[1])) || ((s[1] == s[0]) && (s[3] != s[0]));
    endfunction

    function automatic logic [3:0] wsc_next(input logic [3:0] s, input logic [2:0] c);
        logic [3:0] n;
        n    = s;
        n[3] = ~s[3];
        for (int i = 0; i < 3; i++)
            if (c[i] && (s[i] == s[3])) n[i] = ~s[i];
        return n;
    endfunction

    initial begin
        int mc;
        mc = SAFE ? 4 : 3;

        // Test 1: dir=0 solve from IDLE
        push(1, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0);
        push_run(0, 0, 0);
        // Test 3: bad start position
        push(1, 0, 4'b0100, 0, 0, 1, 0, 0, 7, 0, 1);
        push(0, 0, 4'b0100, 0, 1, 0, 0, 0, 0, 0, 1);
        push(0, 0, 4'b0100, 0, 0, 0, 1, 1, 0, 0, 1);
        // Test 4: mismatch at step 2, then recover
        push(1, 0, 4'b0000, 0, 0, 0, 1, 1, 0, 0, 1);
        push(0, 0, 4'b0000, 3'b010, 1, 0, 0, 0, 0, 0, 1);
        push(0, 0, 4'b1010, 0, 1, 0, 0, 0, 1, 0, 1);
        push(0, 0, 4'b0110, 0, 1, 0, 0, 0, 2, 0, 1);
        push(0, 0, 4'b0110, 0, 0, 0, 1, mc, 2, 0, 1);
        push(1, 0, 4'b0000, 0, 0, 0, 1, mc, 2, 0, 1);
        push_run(0, 0, 1);
        // Test 2: dir=1 solve, back-to-back from DONE
        push(1, 0, 4'b1111, 0, 0, 1, 0, 0, 7, 0, 2);
        push_run(1, 0, 2);
        // Test 5: abort at step 4
        push(1, 0, 4'b0000, 0, 0, 1, 0, 0, 7, 1, 3);
        push(0, 0, 4'b0000, 3'b010, 1, 0, 0, 0, 0, 1, 3);
        push(0, 0, 4'b1010, 0, 1, 0, 0, 0, 1, 0, 3);
        push(0, 0, 4'b0010, 3'b100, 1, 0, 0, 0, 2, 0, 3);
        push(0, 0, 4'b1110, 3'b010, 1, 0, 0, 0, 3, 0, 3);
        push(0, 1, 4'b0100, 0, 1, 0, 0, 0, 4, 0, 3);
        push(0, 0, 4'b1100, 0, 0, 0, 0, 0, 4, 0, 3);
        // Test 6: farmer frozen on far bank in ARM
        push(1, 0, 4'b1000, 0, 0, 0, 0, 0, 4, 0, 3);
        if (SAFE) begin
            push(0, 0, 4'b1000, 0, 1, 0, 0, 0, 0, 0, 3);
            push(0, 0, 4'b1000, 0, 0, 0, 1, 4, 0, 0, 3);
        end else begin
            for (int i = 0; i < int'(WMX); i++)
                push(0, 0, 4'b1000, 0, 1, 0, 0, 0, 0, 0, 3);
            push(0, 0, 4'b1000, 0, 0, 0, 1, 2, 0, 0, 3);
        end
`ifdef WSC_CTRL_SAFETY_EN
        push(1, 0, 4'b0000, 0, 0, 0, 1, 4, 0, 0, 3);
        push(0, 0, 4'b0000, 3'b010, 1, 0, 0, 0, 0, 0, 3);
        push(0, 0, 4'b1010, 0, 1, 0, 0, 0, 1, 0, 3);
        push(0, 0, 4'b1001, 0, 1, 0, 0, 0, 2, 0, 3);
        push(0, 0, 4'b1001, 0, 0, 0, 1, 4, 2, 0, 3);
`endif

        // Reset values
        @(negedge clk);
        chk("reset", obs(), 32'h0);
        rst = 1'b1;
        @(posedge clk); #1;

        foreach (tbl[i]) begin
            start = tbl[i].start;
            abort = tbl[i].abort;
            state = tbl[i].st;
            @(negedge clk);
            chk($sformatf("vec%0d", i), obs(),
                32'({tbl[i].cmd, tbl[i].busy, tbl[i].done, tbl[i].err, tbl[i].code,
                     tbl[i].step, tbl[i].dir, tbl[i].runs}));
            @(posedge clk); #1;
        end
        start = 1'b0;
        abort = 1'b0;

        // Asynchronous reset in the middle of a run
        start = 1'b1; state = 4'b0000;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        state = 4'b1010;
        @(posedge clk); #1;
        state = 4'b0010;
        #2 rst = 1'b0;
        #1 chk("async_rst", obs(), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;

        // Back-to-back runs with start held high; counter must saturate
        start = 1'b1; state = 4'b0000;
        @(posedge clk); #1;
        for (int n = 1; n <= 17; n++) begin
            state = 4'b0000;
            @(posedge clk); #1;
            for (int k = 1; k < 7; k++) begin
                state = TRAJ[k];
                @(posedge clk); #1;
            end
            state = 4'b1111;
            @(posedge clk); #1;
            state = 4'b0000;
            @(negedge clk);
            chk($sformatf("sat_run%0d", n), 32'({done, busy, runs_ok}),
                32'({1'b1, 1'b0, CW'((n > 15) ? 15 : n)}));
            @(posedge clk); #1;
        end
        start = 1'b0;

        // Randomized run against the puzzle-level model
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        begin
            int ph, mstep, mdir, mcode, mwait, mruns;
            logic [3:0] pz, st;
            logic [2:0] ecmd;
            logic [31:0] expv;
            ph = 0; mstep = 0; mdir = 0; mcode = 0; mwait = 0; mruns = 0;
            pz = 4'b0000;
            for (int cyc = 0; cyc < 1500; cyc++) begin
                start = ($urandom_range(3) == 0);
                abort = ($urandom_range(39) == 0);
                st    = ($urandom_range(9) == 0) ? 4'($urandom) : pz;
                state = st;
                ecmd  = 3'b000;
                expv  = 32'({3'b000, 1'(ph >= 1 && ph <= 3), 1'(ph == 4), 1'(ph == 5),
                             3'(mcode), 3'(mstep), 1'(mdir), CW'(mruns)});
                if (abort) begin
                    ph = 0; mcode = 0;
                end else if (SAFE && ph >= 1 && ph <= 3 && hz(st)) begin
                    ph = 5; mcode = 4;
                end else if (ph == 0 || ph == 4 || ph == 5) begin
                    if (start) begin ph = 1; mcode = 0; mwait = 0; mstep = 0; end
                end else if (ph == 1) begin
                    if (st[2:0] != 3'b000 && st[2:0] != 3'b111) begin
                        ph = 5; mcode = 1;
                    end else if (st == 4'b0000 || st == 4'b1111) begin
                        ecmd = CMDS[0]; mdir = int'(st[0]); mstep = 1; ph = 2;
                    end else begin
                        mwait++;
                        if (mwait >= int'(WMX)) begin ph = 5; mcode = 2; end
                    end
                end else if (ph == 2) begin
                    if (st == (TRAJ[mstep] ^ {4{1'(mdir)}})) begin
                        ecmd = CMDS[mstep];
                        mstep++;
                        if (mstep == 7) ph = 3;
                    end else begin
                        ph = 5; mcode = 3;
                    end
                end else begin
                    if (st == {4{~1'(mdir)}}) begin
                        ph = 4;
                        if (mruns < 15) mruns++;
                    end else begin
                        ph = 5; mcode = 3;
                    end
                end
                expv[16:14] = ecmd;
                @(negedge clk);
                chk($sformatf("rand%0d", cyc), obs(), expv);
                pz = wsc_next(st, ecmd);
                @(posedge clk); #1;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
